rbe_normquant_sequencer: RTL and testbench

Controller that time-multiplexes one `rbe_normquant_multiplier` instance over a stream of per-channel accumulators. It holds a per-channel parameter file (norm multiplier, norm adder), sequences a job of `n_chan × n_pix` accumulator beats through the multiplier, then shifts, clips and emits quantized outputs on a valid/ready stream with back-pressure. It sits between the accumulator readout and the output streamer of the engine.

---
 rtl/rbe_normquant_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_rbe_normquant_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbe_normquant_sequencer.sv
// Normalization/quantization sequencer: streams n_chan x n_pix accumulator
// beats through one shared multiplier, then shifts, clips and emits them.
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (synchronous abort)
//   par_we_i/par_addr_i/par_mult_i/par_add_i : per-channel parameter file write
//   start_i/n_chan_i/n_pix_i/shift_i        : job setup
//   acc_valid_i/acc_ready_o/acc_data_i      : accumulator input stream
//   mult_*_o / mult_product_i               : attached multiplier control and operands
//   out_valid_o/out_ready_i/out_data_o/out_last_o : quantized output stream
//   busy_o, done_o                          : status

module rbe_normquant_sequencer #(
    parameter int NMS       = 16,
    parameter int NAS       = 32,
    parameter int ACC       = 32,
    parameter int NCH       = 32,
    parameter int QNT       = 8,
    parameter int MULT_PIPE = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   par_we_i,
    input  logic [$clog2(NCH)-1:0] par_addr_i,
    input  logic [NMS:0]           par_mult_i,
    input  logic [NAS-1:0]         par_add_i,
    input  logic                   start_i,
    input  logic [$clog2(NCH):0]   n_chan_i,
    input  logic [15:0]            n_pix_i,
    input  logic [4:0]             shift_i,
    input  logic                   acc_valid_i,
    output logic                   acc_ready_o,
    input  logic [ACC-1:0]         acc_data_i,
    output logic                   mult_enable_o,
    output logic                   mult_clear_o,
    output logic [NMS:0]           mult_norm_mult_o,
    output logic [NAS-1:0]         mult_norm_add_o,
    output logic [ACC-1:0]         mult_acc_o,
    input  logic [NMS+ACC-1:0]     mult_product_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [QNT-1:0]         out_data_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int CW = $clog2(NCH);
    localparam int PW = NMS + ACC;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]     state_q;
    logic [NMS:0]   mult_file_q [NCH];
    logic [NAS-1:0] add_file_q  [NCH];

    logic [CW-1:0]  ch_cnt_q;
    logic [15:0]    pix_cnt_q;
    logic [CW:0]    n_chan_q;
    logic [15:0]    n_pix_q;
    logic [4:0]     shift_q;

    logic           p_valid_q;
    logic           p_last_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic [QNT-1:0] out_data_q;
    logic           done_q;

    logic           stall;
    logic           fire;
    logic           last_beat;
    logic           ch_wrap;
    logic           pix_wrap;
    logic           start_acc;
    logic           job_ok;
    logic           par_wr;
    logic           ld;
    logic           ld_last;
    logic           out_hs;

    logic signed [PW-1:0] q;
    logic [QNT-1:0]       qnt;

    assign stall       = out_valid_q & ~out_ready_i;
    assign acc_ready_o = (state_q == S_RUN) & ~stall;
    assign fire        = acc_valid_i & acc_ready_o;
    assign out_hs      = out_valid_q & out_ready_i;

    assign ch_wrap   = ({1'b0, ch_cnt_q} == n_chan_q - (CW+1)'(1));
    assign pix_wrap  = (pix_cnt_q == n_pix_q - 16'd1);
    assign last_beat = ch_wrap & pix_wrap;

    assign start_acc = (state_q == S_IDLE) & start_i & ~clear_i;
    assign job_ok    = (n_chan_i != '0) && (n_chan_i <= (CW+1)'(NCH))
                       && (n_pix_i != 16'd0);
    assign par_wr    = (state_q == S_IDLE) & par_we_i & ~clear_i
                       & ({1'b0, par_addr_i} < (CW+1)'(NCH));

    // Enable is held low while reset is applied; afterwards the multiplier
    // advances whenever the output side is not stalled.
    assign mult_enable_o    = ~stall & ~rst_i;
    assign mult_clear_o     = clear_i | start_acc;
    assign mult_norm_mult_o = mult_file_q[ch_cnt_q];
    assign mult_norm_add_o  = add_file_q[ch_cnt_q];
    assign mult_acc_o       = acc_data_i;

    // With a registered multiplier the beat tag travels one stage behind fire.
    always_comb begin
        ld      = 1'b0;
        ld_last = 1'b0;
        if (MULT_PIPE != 0) begin
            ld      = p_valid_q & ~stall;
            ld_last = p_last_q;
        end else begin
            ld      = fire;
            ld_last = last_beat;
        end
    end

    assign q = $signed(mult_product_i) >>> shift_q;

    always_comb begin
        qnt = q[QNT-1:0];
        if (q[PW-1]) begin
            qnt = '0;
        end else if (|q[PW-2:QNT]) begin
            qnt = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCH; i++) begin
                mult_file_q[i] <= '0;
                add_file_q[i]  <= '0;
            end
        end else if (par_wr) begin
            mult_file_q[par_addr_i] <= par_mult_i;
            add_file_q[par_addr_i]  <= par_add_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            n_chan_q    <= '0;
            n_pix_q     <= '0;
            shift_q     <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= S_IDLE;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        n_chan_q  <= n_chan_i;
                        n_pix_q   <= n_pix_i;
                        shift_q   <= shift_i;
                        ch_cnt_q  <= '0;
                        pix_cnt_q <= '0;
                        if (job_ok) begin
                            state_q <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (ch_wrap) begin
                            ch_cnt_q  <= '0;
                            pix_cnt_q <= pix_cnt_q + 16'd1;
                        end else begin
                            ch_cnt_q <= ch_cnt_q + CW'(1);
                        end
                        if (last_beat) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_hs && out_last_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (!stall) begin
                p_valid_q <= fire;
                p_last_q  <= fire & last_beat;
            end

            if (ld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= qnt;
                out_last_q  <= ld_last;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_rbe_normquant_sequencer.sv
// Bench for rbe_normquant_sequencer with a registered multiplier model.
// Directed vectors plus job-level sequences for stall, abort and reset.

module tb_rbe_normquant_sequencer;

    localparam int NMS = 16;
    localparam int NAS = 32;
    localparam int ACC = 32;
    localparam int NCH = 4;
    localparam int QNT = 8;
    localparam int MP  = 1;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            clear_i = 1'b0;
    logic            par_we_i = 1'b0;
    logic [1:0]      par_addr_i = '0;
    logic [NMS:0]    par_mult_i = '0;
    logic [NAS-1:0]  par_add_i = '0;
    logic            start_i = 1'b0;
    logic [2:0]      n_chan_i = '0;
    logic [15:0]     n_pix_i = '0;
    logic [4:0]      shift_i = '0;
    logic            acc_valid_i = 1'b0;
    logic            acc_ready_o;
    logic [ACC-1:0]  acc_data_i = '0;
    logic            mult_enable_o;
    logic            mult_clear_o;
    logic [NMS:0]    mult_norm_mult_o;
    logic [NAS-1:0]  mult_norm_add_o;
    logic [ACC-1:0]  mult_acc_o;
    logic [NMS+ACC-1:0] mult_product_i;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic [QNT-1:0]  out_data_o;
    logic            out_last_o;
    logic            busy_o;
    logic            done_o;

    rbe_normquant_sequencer #(
        .NMS(NMS), .NAS(NAS), .ACC(ACC), .NCH(NCH), .QNT(QNT), .MULT_PIPE(MP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .par_we_i(par_we_i), .par_addr_i(par_addr_i),
        .par_mult_i(par_mult_i), .par_add_i(par_add_i),
        .start_i(start_i), .n_chan_i(n_chan_i), .n_pix_i(n_pix_i),
        .shift_i(shift_i),
        .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
        .acc_data_i(acc_data_i),
        .mult_enable_o(mult_enable_o), .mult_clear_o(mult_clear_o),
        .mult_norm_mult_o(mult_norm_mult_o),
        .mult_norm_add_o(mult_norm_add_o), .mult_acc_o(mult_acc_o),
        .mult_product_i(mult_product_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Registered multiplier: product = mult * acc + add.
    logic [NMS+ACC-1:0] prod_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
        end else if (mult_clear_o) begin
            prod_q <= '0;
        end else if (mult_enable_o) begin
            prod_q <= (NMS+ACC)'(longint'($signed(mult_norm_mult_o))
                      * longint'($signed(mult_acc_o))
                      + longint'($signed(mult_norm_add_o)));
        end
    end
    assign mult_product_i = prod_q;

    int n_checks = 0;
    int n_err = 0;

    int acc_src [64];
    int out_q [$];
    bit last_q [$];
    int ref_q [$];
    bit g_done;
    int g_done_cyc;
    int g_last_hs;
    bit g_busy0;

    int pm [4] = '{2, -1, 3, 1};
    int pa [4] = '{0, 10, -6, 100};

    typedef struct {
        int m;
        int a;
        int acc;
        int sh;
        int exp;
    } vec_t;
    vec_t tv [13];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qref(input longint m, input longint a,
                                input longint ad, input int sh);
        longint p;
        p = (m * a + ad) >>> sh;
        if (p < 0) return 0;
        if (p > 255) return 255;
        return int'(p);
    endfunction

    task automatic write_par(input int addr, input int m, input int a);
        par_we_i = 1'b1;
        par_addr_i = 2'(addr);
        par_mult_i = 17'(m);
        par_add_i = 32'(a);
        @(posedge clk_i); #1;
        par_we_i = 1'b0;
    endtask

    task automatic load_main_params();
        for (int i = 0; i < 4; i++) write_par(i, pm[i], pa[i]);
    endtask

    task automatic run_job(input int nc, input int np, input int sh,
                           input bit rnd, input int abort_at,
                           input int we_at);
        int fired;
        int cyc;
        int nb;
        out_q.delete();
        last_q.delete();
        g_done = 1'b0;
        g_done_cyc = -1;
        g_last_hs = -1;
        nb = nc * np;
        n_chan_i = 3'(nc);
        n_pix_i = 16'(np);
        shift_i = 5'(sh);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        fired = 0;
        cyc = 0;
        while (!g_done && cyc < 2000) begin
            if (abort_at >= 0 && fired == abort_at) begin
                acc_valid_i = 1'b0;
                out_ready_i = 1'b1;
                clear_i = 1'b1;
                @(posedge clk_i); #1;
                clear_i = 1'b0;
                break;
            end
            acc_valid_i = (fired < nb) && (!rnd || $urandom_range(1) == 1);
            acc_data_i = 32'(acc_src[fired % 64]);
            out_ready_i = !rnd || $urandom_range(1) == 1;
            par_we_i = (we_at >= 0 && fired == we_at);
            par_addr_i = 2'd0;
            par_mult_i = 17'(99);
            par_add_i = 32'(77);
            @(negedge clk_i);
            if (cyc == 0) g_busy0 = busy_o;
            if (acc_valid_i && acc_ready_o) fired++;
            if (out_valid_o && out_ready_i) begin
                out_q.push_back(int'(out_data_o));
                last_q.push_back(out_last_o);
                if (out_last_o) g_last_hs = cyc;
            end
            if (done_o) begin
                g_done = 1'b1;
                g_done_cyc = cyc;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        acc_valid_i = 1'b0;
        par_we_i = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic check_main(input string tag);
        int e [4] = '{5, 2, 4, 52};
        chk({tag, "_count"}, out_q.size(), 8);
        for (int i = 0; i < out_q.size() && i < 8; i++) begin
            chk($sformatf("%s_data%0d", tag, i), out_q[i], e[i % 4]);
            chk($sformatf("%s_last%0d", tag, i), last_q[i], (i == 7) ? 1 : 0);
        end
        chk({tag, "_busy0"}, g_busy0, 1);
        chk({tag, "_done"}, g_done, 1);
        chk({tag, "_done_cyc"}, g_done_cyc, 10);
        chk({tag, "_done_after_last"}, g_done_cyc, g_last_hs + 1);
    endtask

    task automatic zero_job(input string tag, input int nc, input int np);
        n_chan_i = 3'(nc);
        n_pix_i = 16'(np);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_valid"}, out_valid_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk({tag, "_done_clr"}, done_o, 0);
        chk({tag, "_busy2"}, busy_o, 0);
        chk({tag, "_valid2"}, out_valid_o, 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int saved [$];
        int ch;

        tv[0]  = '{1000, 0, 1000, 0, 255};
        tv[1]  = '{1000, 0, -1000, 0, 0};
        tv[2]  = '{1000, 0, 1000, 31, 0};
        tv[3]  = '{1000, 0, -1000, 31, 0};
        tv[4]  = '{1, 0, 255, 0, 255};
        tv[5]  = '{1, 0, 256, 0, 255};
        tv[6]  = '{1, 0, 254, 0, 254};
        tv[7]  = '{1, -1, 0, 0, 0};
        tv[8]  = '{1, 0, -1, 1, 0};
        tv[9]  = '{2, 0, 127, 1, 127};
        tv[10] = '{1, 0, 513, 1, 255};
        tv[11] = '{-1, 10, 5, 1, 2};
        tv[12] = '{3, -6, 5, 1, 4};

        // Reset state
        #2;
        chk("rst_mult_en", mult_enable_o, 0);
        chk("rst_acc_ready", acc_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_mult_en", mult_enable_o, 1);
        @(posedge clk_i); #1;

        // Main job from the test plan
        load_main_params();
        for (int i = 0; i < 64; i++) acc_src[i] = 5;
        run_job(4, 2, 1, 1'b0, -1, -1);
        check_main("main");

        // Writes during RUN must be ignored
        run_job(4, 2, 1, 1'b0, -1, 2);
        check_main("we_run");
        run_job(4, 2, 1, 1'b0, -1, -1);
        check_main("we_run_after");

        // Abort after three beats
        run_job(4, 2, 1, 1'b0, 3, -1);
        @(negedge clk_i);
        chk("clr_valid", out_valid_o, 0);
        chk("clr_busy", busy_o, 0);
        chk("clr_ready", acc_ready_o, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk($sformatf("clr_nodone%0d", i), done_o, 0);
            chk($sformatf("clr_noval%0d", i), out_valid_o, 0);
        end
        @(posedge clk_i); #1;
        run_job(4, 2, 1, 1'b0, -1, -1);
        check_main("post_clr");

        // 64-beat job: reference run, then with stalls and gaps
        for (int i = 0; i < 64; i++) acc_src[i] = i * 53 - 1500;
        run_job(4, 16, 1, 1'b0, -1, -1);
        chk("bp_ref_count", out_q.size(), 64);
        chk("bp_ref_done_cyc", g_done_cyc, 66);
        ref_q.delete();
        for (int i = 0; i < 64; i++) begin
            ch = i % 4;
            ref_q.push_back(qref(pm[ch], acc_src[i], pa[ch], 1));
        end
        saved = out_q;
        for (int i = 0; i < 64 && i < saved.size(); i++)
            chk($sformatf("bp_ref%0d", i), saved[i], ref_q[i]);
        run_job(4, 16, 1, 1'b1, -1, -1);
        chk("bp_count", out_q.size(), 64);
        chk("bp_done", g_done, 1);
        for (int i = 0; i < 64 && i < out_q.size() && i < saved.size(); i++)
            chk($sformatf("bp%0d", i), out_q[i], saved[i]);
        chk("bp_last", (out_q.size() == 64) ? int'(last_q[63]) : 0, 1);

        // Single-beat vector table
        for (int k = 0; k < 13; k++) begin
            write_par(0, tv[k].m, tv[k].a);
            acc_src[0] = tv[k].acc;
            run_job(1, 1, tv[k].sh, 1'b0, -1, -1);
            chk($sformatf("tv%0d_count", k), out_q.size(), 1);
            if (out_q.size() > 0)
                chk($sformatf("tv%0d_data", k), out_q[0], tv[k].exp);
            chk($sformatf("tv%0d_done", k), g_done, 1);
        end

        // Zero-length jobs
        zero_job("zl_nc0", 0, 1);
        zero_job("zl_nc5", 5, 1);
        zero_job("zl_np0", 4, 0);

        // Reset in the middle of a job
        load_main_params();
        for (int i = 0; i < 64; i++) acc_src[i] = 5;
        n_chan_i = 3'd4;
        n_pix_i = 16'd2;
        shift_i = 5'd1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        acc_valid_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("mrst_acc_ready", acc_ready_o, 0);
        chk("mrst_out_valid", out_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_mult_en", mult_enable_o, 0);
        chk("mrst_data", out_data_o, 0);
        acc_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // File is zero after reset: every output quantizes 0
        for (int i = 0; i < 64; i++) acc_src[i] = 500;
        run_job(4, 1, 0, 1'b0, -1, -1);
        chk("prst_count", out_q.size(), 4);
        for (int i = 0; i < out_q.size(); i++)
            chk($sformatf("prst_data%0d", i), out_q[i], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
